wb_arbiter2: RTL



---
 rtl/wb_arbiter2.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/wb_arbiter2.sv
// Two-master Wishbone arbiter: round-robin whole-cycle grants onto one
// 16-bit slave bus, with a watchdog that aborts unacknowledged strobes.
module wb_arbiter2 #(
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic [18:0] m0_adr_i,
  input  logic [15:0] m0_dat_i,
  output logic [15:0] m0_dat_o,
  input  logic [1:0]  m0_sel_i,
  input  logic        m0_we_i,
  input  logic        m0_tga_i,
  input  logic        m0_stb_i,
  input  logic        m0_cyc_i,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  input  logic [18:0] m1_adr_i,
  input  logic [15:0] m1_dat_i,
  output logic [15:0] m1_dat_o,
  input  logic [1:0]  m1_sel_i,
  input  logic        m1_we_i,
  input  logic        m1_tga_i,
  input  logic        m1_stb_i,
  input  logic        m1_cyc_i,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic [18:0] s_adr_o,
  output logic [15:0] s_dat_o,
  output logic [1:0]  s_sel_o,
  output logic        s_we_o,
  output logic        s_tga_o,
  output logic        s_stb_o,
  output logic        s_cyc_o,
  input  logic [15:0] s_dat_i,
  input  logic        s_ack_i,
  output logic [1:0]  gnt_o,
  output logic [7:0]  to_count_o
);

  typedef enum logic [2:0] {
    IDLE, GNT0, GNT1, ERR0, ERR1
  } state_t;

  state_t          state_q, state_d;
  logic            last_q, last_d;
  logic [TO_W-1:0] wd_q, wd_d;
  logic [7:0]      to_cnt_q, to_cnt_d;
  logic            stall;
  logic            expire;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q  <= IDLE;
      last_q   <= 1'b1;
      wd_q     <= '0;
      to_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      wd_q     <= wd_d;
      to_cnt_q <= to_cnt_d;
    end
  end

  // A release outranks a timeout; an ack on the terminal count clears stall.
  assign stall  = s_stb_o & ~s_ack_i;
  assign expire = stall && (wd_q == TO_W'(TIMEOUT - 1));

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    wd_d     = '0;
    to_cnt_d = to_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (m0_cyc_i && (!m1_cyc_i || last_q))
          state_d = GNT0;
        else if (m1_cyc_i)
          state_d = GNT1;
      end
      GNT0: begin
        if (!m0_cyc_i) begin
          last_d  = 1'b0;
          state_d = m1_cyc_i ? GNT1 : IDLE;
        end else if (expire) begin
          state_d = ERR0;
        end else if (stall) begin
          wd_d = wd_q + 1'b1;
        end
      end
      GNT1: begin
        if (!m1_cyc_i) begin
          last_d  = 1'b1;
          state_d = m0_cyc_i ? GNT0 : IDLE;
        end else if (expire) begin
          state_d = ERR1;
        end else if (stall) begin
          wd_d = wd_q + 1'b1;
        end
      end
      ERR0: begin
        last_d  = 1'b0;
        state_d = IDLE;
        if (to_cnt_q != 8'hFF)
          to_cnt_d = to_cnt_q + 8'd1;
      end
      ERR1: begin
        last_d  = 1'b1;
        state_d = IDLE;
        if (to_cnt_q != 8'hFF)
          to_cnt_d = to_cnt_q + 8'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    s_adr_o  = '0;
    s_dat_o  = '0;
    s_sel_o  = '0;
    s_we_o   = 1'b0;
    s_tga_o  = 1'b0;
    s_stb_o  = 1'b0;
    s_cyc_o  = 1'b0;
    gnt_o    = 2'b00;
    m0_ack_o = 1'b0;
    m1_ack_o = 1'b0;
    m0_err_o = 1'b0;
    m1_err_o = 1'b0;
    unique case (state_q)
      GNT0: begin
        s_adr_o  = m0_adr_i;
        s_dat_o  = m0_dat_i;
        s_sel_o  = m0_sel_i;
        s_we_o   = m0_we_i;
        s_tga_o  = m0_tga_i;
        s_stb_o  = m0_stb_i;
        s_cyc_o  = m0_cyc_i;
        gnt_o    = 2'b01;
        m0_ack_o = s_ack_i;
      end
      GNT1: begin
        s_adr_o  = m1_adr_i;
        s_dat_o  = m1_dat_i;
        s_sel_o  = m1_sel_i;
        s_we_o   = m1_we_i;
        s_tga_o  = m1_tga_i;
        s_stb_o  = m1_stb_i;
        s_cyc_o  = m1_cyc_i;
        gnt_o    = 2'b10;
        m1_ack_o = s_ack_i;
      end
      ERR0:    m0_err_o = 1'b1;
      ERR1:    m1_err_o = 1'b1;
      default: ;
    endcase
  end

  assign m0_dat_o   = s_dat_i;
  assign m1_dat_o   = s_dat_i;
  assign to_count_o = to_cnt_q;

endmodule
